// File: rtl/io_read_ctrl.sv
// Blocking switch read gated by a debounced confirm button,
// plus a non-blocking read of the debounced button level.
module io_read_ctrl #(
  parameter int DEBOUNCE_CYCLES = 200000,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ior,
  input  logic        switchctrl,
  input  logic        statusctrl,
  input  logic        confirm_btn,
  input  logic [15:0] ioread_data_switch,
  output logic [15:0] ioread_data,
  output logic        io_stall,
  output logic        io_done
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] WAIT_REL   = 2'd1;
  localparam logic [1:0] WAIT_PRESS = 2'd2;
  localparam logic [1:0] DONE       = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             btn_s;
  logic             btn_db;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             req_sw;
  logic             req_st;
  logic             capture;

  assign req_sw  = ior & switchctrl;
  assign req_st  = ior & statusctrl & ~switchctrl;
  assign capture = (state == WAIT_PRESS) & ior & btn_db;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      sync1 <= confirm_btn;
      btn_s <= sync1;
    end
  end

  // Level flips only after a full run of disagreeing samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      btn_db <= 1'b0;
    end else if (btn_s == btn_db) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt    <= '0;
      btn_db <= ~btn_db;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (req_sw) state_nxt = WAIT_REL;
      end
      WAIT_REL: begin
        if (!ior)         state_nxt = IDLE;
        else if (!btn_db) state_nxt = WAIT_PRESS;
      end
      WAIT_PRESS: begin
        if (!ior)        state_nxt = IDLE;
        else if (btn_db) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ioread_data <= '0;
    end else if (state == IDLE && req_st) begin
      ioread_data <= {15'b0, btn_db};
    end else if (capture) begin
      ioread_data <= ioread_data_switch;
    end
  end

  // Stall is combinational so the request cycle itself is held.
  assign io_stall = ((state == IDLE) & req_sw)
                  | (state == WAIT_REL)
                  | (state == WAIT_PRESS);
  assign io_done  = (state == DONE);

endmodule

// File: tb/tb_io_read_ctrl.sv
// Randomized bench for io_read_ctrl against a transaction-level
// model with a sliding-window debounce reference.
module tb_io_read_ctrl;

  localparam int D = 4;

  logic        clk;
  logic        rst_n;
  logic        ior;
  logic        switchctrl;
  logic        statusctrl;
  logic        confirm_btn;
  logic [15:0] sw;
  logic [15:0] ioread_data;
  logic        io_stall;
  logic        io_done;

  int checks;
  int failures;

  io_read_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .ior                (ior),
    .switchctrl         (switchctrl),
    .statusctrl         (statusctrl),
    .confirm_btn        (confirm_btn),
    .ioread_data_switch (sw),
    .ioread_data        (ioread_data),
    .io_stall           (io_stall),
    .io_done            (io_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: raw button history window, pending-read flags.
  logic [D:0]  raw_h;
  logic        m_db;
  logic        m_busy;
  logic        m_armed;
  logic        m_done;
  logic [15:0] m_data;
  logic        m_stall;

  assign m_stall = m_busy
                 | (!m_busy & !m_done & ior & switchctrl);

  always @(posedge clk) begin
    if (!rst_n) begin
      raw_h   <= '0;
      m_db    <= 1'b0;
      m_busy  <= 1'b0;
      m_armed <= 1'b0;
      m_done  <= 1'b0;
      m_data  <= '0;
    end else begin
      m_done <= 1'b0;
      if (!m_done) begin
        if (!m_busy) begin
          if (ior && switchctrl) begin
            m_busy  <= 1'b1;
            m_armed <= 1'b0;
          end else if (ior && statusctrl) begin
            m_data <= {15'b0, m_db};
          end
        end else if (!ior) begin
          m_busy <= 1'b0;
        end else if (!m_armed) begin
          if (!m_db) m_armed <= 1'b1;
        end else if (m_db) begin
          m_data <= sw;
          m_busy <= 1'b0;
          m_done <= 1'b1;
        end
      end
      // Synchronized samples lag raw by two edges.
      if (raw_h[D:1] == {D{~m_db}}) m_db <= ~m_db;
      raw_h <= {raw_h[D-1:0], confirm_btn};
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    ior = 1'b1;
    switchctrl = 1'b1;
    statusctrl = 1'b0;
    confirm_btn = 1'b0;
    sw = 16'hFFFF;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (ioread_data !== 16'h0) begin
        failures++;
        $display("FAIL reset_data: got %h want 0000", ioread_data);
      end
      checks++;
      if (io_done !== 1'b0) begin
        failures++;
        $display("FAIL reset_done: got %b want 0", io_done);
      end
      checks++;
      if (io_stall !== 1'b1) begin
        failures++;
        $display("FAIL reset_stall_comb: got %b want 1", io_stall);
      end
    end
    ior = 1'b0;
    switchctrl = 1'b0;
    #1;
    checks++;
    if (io_stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_stall_drop: got %b want 0", io_stall);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    bit got = 0;
    sw = 16'hA5C3;
    ior = 1'b1;
    switchctrl = 1'b1;
    #1;
    checks++;
    if (io_stall !== 1'b1) begin
      failures++;
      $display("FAIL basic_req_stall: got %b want 1", io_stall);
    end
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge clk);
      checks++;
      if ({io_stall, io_done, ioread_data} !==
          {m_stall, m_done, m_data}) begin
        failures++;
        $display("FAIL basic_cycle: got s=%b d=%b q=%h want s=%b d=%b q=%h",
                 io_stall, io_done, ioread_data, m_stall, m_done, m_data);
      end
      if (io_done === 1'b1) begin
        got = 1;
        checks++;
        if (ioread_data !== 16'hA5C3 || io_stall !== 1'b0 || c != 16) begin
          failures++;
          $display("FAIL basic_done: got q=%h s=%b at %0d want A5C3 0 at 16",
                   ioread_data, io_stall, c);
        end
        ior = 1'b0;
        switchctrl = 1'b0;
      end
      if (c == 9) confirm_btn = 1'b1;
    end
    if (!got) begin
      failures++;
      $display("FAIL basic_timeout: got no io_done want one");
    end
  endtask

  task automatic test_held();
    bit got = 0;
    logic [15:0] prev;
    @(negedge clk);
    sw = 16'($urandom);
    ior = 1'b1;
    switchctrl = 1'b1;
    repeat (15) begin
      @(negedge clk);
      checks++;
      if (io_stall !== 1'b1 || io_done !== 1'b0 ||
          ioread_data !== m_data) begin
        failures++;
        $display("FAIL held_wait: got s=%b d=%b q=%h want 1 0 %h",
                 io_stall, io_done, ioread_data, m_data);
      end
      sw = 16'($urandom);
    end
    confirm_btn = 1'b0;
    repeat (12) begin
      @(negedge clk);
      checks++;
      if (io_stall !== 1'b1 || io_done !== 1'b0) begin
        failures++;
        $display("FAIL held_release: got s=%b d=%b want 1 0",
                 io_stall, io_done);
      end
      sw = 16'($urandom);
    end
    confirm_btn = 1'b1;
    prev = sw;
    for (int c = 0; c < 30 && !got; c++) begin
      @(negedge clk);
      checks++;
      if ({io_stall, io_done, ioread_data} !==
          {m_stall, m_done, m_data}) begin
        failures++;
        $display("FAIL held_cycle: got s=%b d=%b q=%h want s=%b d=%b q=%h",
                 io_stall, io_done, ioread_data, m_stall, m_done, m_data);
      end
      if (io_done === 1'b1) begin
        got = 1;
        checks++;
        if (ioread_data !== prev) begin
          failures++;
          $display("FAIL held_capture: got %h want %h", ioread_data, prev);
        end
        ior = 1'b0;
        switchctrl = 1'b0;
      end
      sw = 16'($urandom);
      prev = sw;
    end
    if (!got) begin
      failures++;
      $display("FAIL held_timeout: got no io_done want one");
    end
  endtask

  task automatic test_bounce();
    confirm_btn = 1'b0;
    repeat (10) @(negedge clk);
    ior = 1'b1;
    switchctrl = 1'b1;
    for (int p = 0; p < 20; p++) begin
      int w = int'($urandom_range(1, 3));
      int g = int'($urandom_range(1, 4));
      confirm_btn = 1'b1;
      for (int i = 0; i < w + g; i++) begin
        @(negedge clk);
        checks++;
        if (io_stall !== 1'b1 || io_done !== 1'b0 || m_db !== 1'b0) begin
          failures++;
          $display("FAIL bounce: got s=%b d=%b db=%b want 1 0 0",
                   io_stall, io_done, m_db);
        end
        if (i == w - 1) confirm_btn = 1'b0;
      end
    end
    ior = 1'b0;
    switchctrl = 1'b0;
    @(negedge clk);
    checks++;
    if (io_stall !== 1'b0 || io_done !== 1'b0) begin
      failures++;
      $display("FAIL bounce_abort: got s=%b d=%b want 0 0",
               io_stall, io_done);
    end
  endtask

  task automatic test_abort();
    bit got = 0;
    logic [15:0] old;
    logic [15:0] want;
    old = m_data;
    ior = 1'b1;
    switchctrl = 1'b1;
    sw = ~old;
    repeat (3) @(negedge clk);
    ior = 1'b0;
    switchctrl = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (io_stall !== 1'b0 || io_done !== 1'b0 || ioread_data !== old) begin
        failures++;
        $display("FAIL abort: got s=%b d=%b q=%h want 0 0 %h",
                 io_stall, io_done, ioread_data, old);
      end
    end
    ior = 1'b1;
    switchctrl = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    ior = 1'b0;
    switchctrl = 1'b0;
    @(negedge clk);
    checks++;
    if (io_stall !== 1'b0 || io_done !== 1'b0 || ioread_data !== 16'h0) begin
      failures++;
      $display("FAIL reset_midwait: got s=%b d=%b q=%h want 0 0 0000",
               io_stall, io_done, ioread_data);
    end
    rst_n = 1'b1;
    confirm_btn = 1'b1;
    repeat (8) @(negedge clk);
    ior = 1'b1;
    switchctrl = 1'b1;
    statusctrl = 1'b1;
    want = 16'($urandom) | 16'h0100;
    sw = want;
    #1;
    checks++;
    if (io_stall !== 1'b1) begin
      failures++;
      $display("FAIL prio_stall: got %b want 1", io_stall);
    end
    @(negedge clk);
    checks++;
    if (ioread_data !== 16'h0 || io_stall !== 1'b1) begin
      failures++;
      $display("FAIL prio_path: got q=%h s=%b want 0000 1",
               ioread_data, io_stall);
    end
    confirm_btn = 1'b0;
    repeat (10) @(negedge clk);
    confirm_btn = 1'b1;
    for (int c = 0; c < 30 && !got; c++) begin
      @(negedge clk);
      if (io_done === 1'b1) begin
        got = 1;
        checks++;
        if (ioread_data !== want) begin
          failures++;
          $display("FAIL prio_capture: got %h want %h", ioread_data, want);
        end
        ior = 1'b0;
        switchctrl = 1'b0;
        statusctrl = 1'b0;
      end
    end
    if (!got) begin
      failures++;
      $display("FAIL prio_timeout: got no io_done want one");
    end
  endtask

  task automatic test_status();
    logic [15:0] want;
    for (int k = 0; k < 2; k++) begin
      confirm_btn = (k == 0);
      want = (k == 0) ? 16'h0001 : 16'h0000;
      repeat (10) @(negedge clk);
      ior = 1'b1;
      statusctrl = 1'b1;
      #1;
      checks++;
      if (io_stall !== 1'b0) begin
        failures++;
        $display("FAIL status_stall: got %b want 0", io_stall);
      end
      @(negedge clk);
      checks++;
      if (ioread_data !== want || io_stall !== 1'b0 || io_done !== 1'b0) begin
        failures++;
        $display("FAIL status_data: got q=%h s=%b d=%b want %h 0 0",
                 ioread_data, io_stall, io_done, want);
      end
      ior = 1'b0;
      statusctrl = 1'b0;
    end
  endtask

  task automatic test_random();
    int hold = 0;
    int dones = 0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      checks++;
      if ({io_stall, io_done, ioread_data} !==
          {m_stall, m_done, m_data}) begin
        failures++;
        $display("FAIL random_cycle %0d: got s=%b d=%b q=%h want s=%b d=%b q=%h",
                 c, io_stall, io_done, ioread_data, m_stall, m_done, m_data);
      end
      if (io_done === 1'b1) dones++;
      if (hold == 0) begin
        confirm_btn = ~confirm_btn;
        hold = int'($urandom_range(1, 12));
      end
      hold--;
      sw = 16'($urandom);
      if (m_busy) begin
        ior = ($urandom_range(0, 29) != 0);
      end else begin
        ior = 1'($urandom_range(0, 1));
        switchctrl = 1'($urandom_range(0, 1));
        statusctrl = 1'($urandom_range(0, 1));
      end
    end
    checks++;
    if (dones == 0) begin
      failures++;
      $display("FAIL random_progress: got 0 dones want >0");
    end
    ior = 1'b0;
    switchctrl = 1'b0;
    statusctrl = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_held();
    test_bounce();
    test_abort();
    test_status();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
